// File: rtl/uart_pkg.sv
// uart_pkg: constants and the FSM state type shared by the UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period timer for the UART transmitter.
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset
//   en_i        count while high; held at zero while low
//   bit_done_o  one-cycle pulse on the last cycle of every CLKS_PER_BIT period
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic bit_done_o
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter wraps to zero on bit_done, so every bit boundary restarts the
    // period; dropping en_i parks it at zero so the next frame starts clean.
    always_comb begin
        bit_done_o = en_i && (cnt_q == LAST);
        cnt_d      = cnt_q;
        if (!en_i || bit_done_o) cnt_d = '0;
        else                     cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined).
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset, priority over start
//   start    transmit request, accepted only when idle
//   data_in  byte captured on the accepting edge
//   tx       registered serial line, idles high
//   busy     registered, high for the whole frame
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between data bit 7 and the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy
);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        tx_q;
    logic        busy_q;
    logic        bit_done;
`ifdef UART_TX_PARITY_EN
    logic        parity_q;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (state_q != IDLE),
        .bit_done_o (bit_done)
    );

    // tx_q always holds the level of the bit currently on the line; each
    // bit_done loads the next one, so tx changes exactly on bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= data_in;
                        bit_idx_q <= '0;
                        tx_q      <= START_BIT;
                        busy_q    <= 1'b1;
                        state_q   <= START;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^data_in;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        // bit_idx_q counts data bits already completed.
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= STOP_BIT;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        tx_q    <= STOP_BIT;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        tx_q    <= IDLE_LEVEL;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (CLKS_PER_BIT=2,
// clk period 5). Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_uart_tx;

    localparam int CPB = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FC = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy)
    );

    initial begin
        forever begin
            #2 clk = 1'b1;
            #3 clk = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records tx per cycle for one frame starting with the current cycle and
    // counts busy cycles. Optionally pulses start for one cycle at poke_at.
    task automatic collect(input int poke_at, input logic [7:0] poke_d,
                           output logic [FC-1:0] txs, output int bcnt);
        bcnt = 0;
        for (int i = 0; i < FC; i++) begin
            txs[i] = tx;
            if (busy === 1'b1) bcnt++;
            if (poke_at >= 0 && i == poke_at) begin
                start   = 1'b1;
                data_in = poke_d;
            end else if (poke_at >= 0 && i == poke_at + 1) begin
                start = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL reset_hold c%0d tx=%b busy=%b want tx=1 busy=0", c, tx, busy);
            end
        end
        rst = 1'b0;
        step();
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_release tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_single();
        logic [FC-1:0] txs;
        logic [NB-1:0] exp;
        int bcnt;
`ifdef UART_TX_PARITY_EN
        exp = 11'b1_0_00000011_0;
`else
        exp = 10'b1_00000011_0;
`endif
        data_in = 8'h03; start = 1'b1;
        step();
        total++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL single_accept tx=%b busy=%b want tx=0 busy=1", tx, busy);
        end
        start = 1'b0;
        data_in = 8'hFC;  // must not disturb the captured byte
        collect(-1, 8'h00, txs, bcnt);
        for (int i = 0; i < FC; i++) begin
            total++;
            if (txs[i] !== exp[i / CPB]) begin
                bad++; $display("FAIL single_tx cyc%0d got=%b want=%b", i, txs[i], exp[i / CPB]);
            end
        end
        total++;
        if (bcnt !== FC) begin
            bad++; $display("FAIL single_busy_len got=%0d want=%0d", bcnt, FC);
        end
        for (int c = 0; c < 2; c++) begin
            total++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL single_idle c%0d tx=%b busy=%b want tx=1 busy=0", c, tx, busy);
            end
            step();
        end
    endtask

    task automatic test_busy_ignore();
        logic [FC-1:0] txs;
        logic [NB-1:0] exp;
        int bcnt;
`ifdef UART_TX_PARITY_EN
        exp = 11'b1_0_10100101_0;
`else
        exp = 10'b1_10100101_0;
`endif
        data_in = 8'hA5; start = 1'b1;
        step();
        start = 1'b0;
        collect(7, 8'hFF, txs, bcnt);
        for (int i = 0; i < FC; i++) begin
            total++;
            if (txs[i] !== exp[i / CPB]) begin
                bad++; $display("FAIL ignore_tx cyc%0d got=%b want=%b", i, txs[i], exp[i / CPB]);
            end
        end
        total++;
        if (bcnt !== FC) begin
            bad++; $display("FAIL ignore_busy_len got=%0d want=%0d", bcnt, FC);
        end
        for (int c = 0; c < 6; c++) begin
            total++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL ignore_no_second c%0d tx=%b busy=%b want tx=1 busy=0", c, tx, busy);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [FC-1:0] txs;
        logic [NB-1:0] exp;
        int bcnt;
`ifdef UART_TX_PARITY_EN
        exp = 11'b1_0_01010101_0;
`else
        exp = 10'b1_01010101_0;
`endif
        data_in = 8'h55; start = 1'b1;
        step();
        for (int f = 0; f < 2; f++) begin
            total++;
            if (tx !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL b2b_accept f%0d tx=%b busy=%b want tx=0 busy=1", f, tx, busy);
            end
            collect(-1, 8'h00, txs, bcnt);
            for (int i = 0; i < FC; i++) begin
                total++;
                if (txs[i] !== exp[i / CPB]) begin
                    bad++; $display("FAIL b2b_tx f%0d cyc%0d got=%b want=%b", f, i, txs[i], exp[i / CPB]);
                end
            end
            total++;
            if (bcnt !== FC) begin
                bad++; $display("FAIL b2b_busy_len f%0d got=%0d want=%0d", f, bcnt, FC);
            end
            // exactly one idle-high cycle between frames
            total++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL b2b_gap f%0d tx=%b busy=%b want tx=1 busy=0", f, tx, busy);
            end
            if (f == 1) start = 1'b0;
            step();
        end
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_stop tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [FC-1:0] txs;
        logic [NB-1:0] exp;
        int bcnt;
`ifdef UART_TX_PARITY_EN
        exp = 11'b1_0_00001111_0;
`else
        exp = 10'b1_00001111_0;
`endif
        data_in = 8'h0F; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) step();
        // now in the first cycle of data bit 3 (value 1)
        total++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_bit3 tx=%b busy=%b want tx=1 busy=1", tx, busy);
        end
        rst = 1'b1; start = 1'b1;  // reset must win over start
        step();
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_abort tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
        rst = 1'b0;  // start still high: accepted on first edge out of reset
        step();
        total++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_restart tx=%b busy=%b want tx=0 busy=1", tx, busy);
        end
        start = 1'b0;
        collect(-1, 8'h00, txs, bcnt);
        for (int i = 0; i < FC; i++) begin
            total++;
            if (txs[i] !== exp[i / CPB]) begin
                bad++; $display("FAIL rstmid_tx cyc%0d got=%b want=%b", i, txs[i], exp[i / CPB]);
            end
        end
        total++;
        if (bcnt !== FC || tx !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_end busy_len=%0d tx=%b busy=%b want %0d,1,0", bcnt, tx, busy, FC);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [FC-1:0] txs;
        logic [NB-1:0] exp;
        int bcnt;
        exp = 11'b1_1_00000111_0;
        data_in = 8'h07; start = 1'b1;
        step();
        start = 1'b0;
        collect(-1, 8'h00, txs, bcnt);
        for (int i = 0; i < FC; i++) begin
            total++;
            if (txs[i] !== exp[i / CPB]) begin
                bad++; $display("FAIL parity_tx cyc%0d got=%b want=%b", i, txs[i], exp[i / CPB]);
            end
        end
        total++;
        if (bcnt !== 22) begin
            bad++; $display("FAIL parity_busy_len got=%0d want=22", bcnt);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2, number of clk cycles per serial bit (integer >= 1).
REQ-002 Port clk  input  1  single system clock; all logic on rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port start  input  1  transmit request, sampled on rising edge.
REQ-005 Port data_in  input  8  byte to transmit; captured when start is accepted.
REQ-006 Port tx  output  1  serial line, idle high; driven from a register.
REQ-007 Port busy  output  1  high while a frame is in progress; driven from a register.

Function
REQ-008 Frame SHALL be 8N1: start bit (0), 8 data bits LSB first, stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-009 FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY when configured).
REQ-010 In IDLE, tx=1 and busy=0.
REQ-011 start=1 in IDLE at edge k SHALL capture data_in into a shift register, enter START, and set tx=0 and busy=1, both visible after edge k (one-cycle latency).
REQ-012 START->DATA after CLKS_PER_BIT cycles; DATA->STOP after bit index 7 has been held CLKS_PER_BIT cycles; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-013 busy SHALL stay high for exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity) and fall on the same edge the FSM returns to IDLE.
REQ-014 start while busy=1 SHALL be ignored; no queuing.
REQ-015 data_in changes after capture SHALL NOT affect the frame in progress.
REQ-016 start held high continuously SHALL cause back-to-back frames: a new frame begins on the first edge in IDLE, so tx=1 for exactly one cycle between frames.
REQ-017 Bit counter SHALL be 3 bits; the cycle counter SHALL be sized $clog2(CLKS_PER_BIT)+1 and reset to 0 at each bit boundary.

Reset
REQ-018 rst=1 at any edge SHALL force IDLE, tx=1, busy=0, and clear the counters and the shift register, including mid-frame; rst takes priority over start.
REQ-019 After rst is released, the first start is accepted on the first edge with rst=0.

Configuration
REQ-020 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL insert an even-parity bit (XOR of the 8 data bits) between bit 7 and the stop bit, lasting CLKS_PER_BIT cycles.
REQ-021 Without UART_TX_PARITY_EN, no parity logic SHALL exist and the frame is 8N1.

Structure
REQ-022 Package uart_pkg SHALL hold the FSM state typedef and constants DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
REQ-023 Bit timing SHALL be isolated in sub-module uart_baud_cnt, which emits a one-cycle bit_done pulse every CLKS_PER_BIT cycles while enabled and restarts when enabled.

Verification (CLKS_PER_BIT=2, clk period 5)
REQ-024 Reset: rst=1 for 2 cycles -> tx=1 and busy=0 throughout and after release.
REQ-025 Single frame: data_in=8'h03, start pulsed 1 cycle -> tx sequence per 2-cycle bit is 0,1,1,0,0,0,0,0,0,1; busy high for exactly 20 cycles; then tx=1 and busy=0.
REQ-026 Busy ignore: data_in=8'hA5 frame, then start pulsed mid-frame with data_in=8'hFF -> frame bits are 1,0,1,0,0,1,0,1 (LSB first) and no second frame follows.
REQ-027 Back-to-back: start held high with data_in=8'h55 -> consecutive frames separated by exactly one idle-high cycle.
REQ-028 Reset mid-frame: rst asserted during bit 3 of 8'h0F -> tx=1 and busy=0 after that edge; next start sends a complete, correct frame.
REQ-029 Parity (UART_TX_PARITY_EN): 8'h03 -> parity bit 0; 8'h07 -> parity bit 1; busy high for 22 cycles.
